// File: rtl/tex_format_pipe.sv
// Multi-lane texel format expander: unpack to A8R8G8B8, then optional alpha
// premultiply and per-byte swizzle, in a 2-stage valid/ready pipeline.
module tex_format_pipe #(
    parameter int NUM_LANES     = 4,
    parameter int TAG_WIDTH     = 8,
    parameter int PERF_CTR_BITS = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NUM_LANES-1:0]     req_mask,
    input  logic [2:0]               req_format,
    input  logic [11:0]              req_swizzle,
    input  logic                     req_premul,
    input  logic [NUM_LANES*32-1:0]  req_texels,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NUM_LANES-1:0]     rsp_mask,
    output logic [NUM_LANES*32-1:0]  rsp_texels,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    output logic [PERF_CTR_BITS-1:0] perf_texels
);

    localparam int TW = NUM_LANES * 32;

    function automatic logic [31:0] unpack_texel(input logic [2:0] fmt, input logic [31:0] t);
        logic [31:0] o;
        case (fmt)
            3'd0:    o = t;
            3'd1:    o = {8'hFF, t[15:11], t[15:13], t[10:5], t[10:9], t[4:0], t[4:2]};
            3'd2:    o = {{8{t[15]}}, t[14:10], t[14:12], t[9:5], t[9:7], t[4:0], t[4:2]};
            3'd3:    o = {t[15:12], t[15:12], t[11:8], t[11:8], t[7:4], t[7:4], t[3:0], t[3:0]};
            3'd4:    o = {t[15:8], t[7:0], t[7:0], t[7:0]};
            3'd5:    o = {8'hFF, t[7:0], t[7:0], t[7:0]};
            default: o = {t[7:0], 24'hFFFFFF};
        endcase
        return o;
    endfunction

    // Rounded c*a/255 without a divider.
    function automatic logic [7:0] premul_ch(input logic [7:0] c, input logic [7:0] a);
        logic [15:0] p;
        logic [16:0] t;
        logic [16:0] s;
        p = {8'd0, c} * {8'd0, a};
        t = {1'b0, p} + 17'd128;
        s = t + {8'd0, t[16:8]};
        return 8'(s >> 8);
    endfunction

    function automatic logic [7:0] sel_byte(input logic [2:0] sel, input logic [31:0] px);
        logic [7:0] b;
        case (sel)
            3'd0:    b = px[7:0];
            3'd1:    b = px[15:8];
            3'd2:    b = px[23:16];
            3'd3:    b = px[31:24];
            3'd5:    b = 8'hFF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic                     s1_valid, s2_valid;
    logic [TW-1:0]            s1_data, s2_data;
    logic [NUM_LANES-1:0]     s1_mask, s2_mask;
    logic [TAG_WIDTH-1:0]     s1_tag, s2_tag;
    logic [11:0]              s1_swizzle;
    logic                     s1_premul;
    logic [TW-1:0]            s1_next, s2_next;
    logic [PERF_CTR_BITS-1:0] pop;
    logic                     s1_advance, s2_advance;

    assign s2_advance = !s2_valid || rsp_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign req_ready  = s1_advance;

    always_comb begin
        s1_next = '0;
        for (int i = 0; i < NUM_LANES; i++)
            s1_next[32*i +: 32] = unpack_texel(req_format, req_texels[32*i +: 32]);
    end

    always_comb begin
        logic [31:0] px;
        logic [31:0] pm;
        s2_next = '0;
        px = '0;
        pm = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            px = s1_data[32*i +: 32];
            pm = px;
            if (s1_premul)
                pm = {px[31:24], premul_ch(px[23:16], px[31:24]),
                      premul_ch(px[15:8], px[31:24]), premul_ch(px[7:0], px[31:24])};
            if (s1_mask[i])
                for (int k = 0; k < 4; k++)
                    s2_next[32*i + 8*k +: 8] = sel_byte(s1_swizzle[3*k +: 3], pm);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++)
            pop = pop + PERF_CTR_BITS'(s2_mask[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_mask     <= '0;
            s1_tag      <= '0;
            s1_swizzle  <= '0;
            s1_premul   <= 1'b0;
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_mask     <= '0;
            s2_tag      <= '0;
            perf_texels <= '0;
        end else begin
            if (s1_advance) begin
                s1_valid <= req_valid;
                if (req_valid) begin
                    s1_data    <= s1_next;
                    s1_mask    <= req_mask;
                    s1_tag     <= req_tag;
                    s1_swizzle <= req_swizzle;
                    s1_premul  <= req_premul;
                end
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s2_next;
                    s2_mask <= s1_mask;
                    s2_tag  <= s1_tag;
                end
            end
            if (s2_valid && rsp_ready)
                perf_texels <= perf_texels + pop;
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_texels = s2_data;
    assign rsp_mask   = s2_mask;
    assign rsp_tag    = s2_tag;

endmodule

// File: tb/tb_tex_format_pipe.sv
// Directed bench for tex_format_pipe: format/premul/swizzle vector table,
// a backpressured stream, and an asynchronous reset while the pipe is full.
module tb_tex_format_pipe;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_mask;
    logic [2:0]   req_format;
    logic [11:0]  req_swizzle;
    logic         req_premul;
    logic [127:0] req_texels;
    logic [7:0]   req_tag;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [3:0]   rsp_mask;
    logic [127:0] rsp_texels;
    logic [7:0]   rsp_tag;
    logic [31:0]  perf_texels;

    tex_format_pipe #(.NUM_LANES(4), .TAG_WIDTH(8), .PERF_CTR_BITS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
        .req_format(req_format), .req_swizzle(req_swizzle), .req_premul(req_premul),
        .req_texels(req_texels), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
        .rsp_texels(rsp_texels), .rsp_tag(rsp_tag), .perf_texels(perf_texels)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   fmt;
        logic [11:0]  swz;
        logic         premul;
        logic [3:0]   mask;
        logic [127:0] tex;
        logic [127:0] exp;
    } vec_t;

    vec_t        vecs[12];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_perf = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [127:0] stex(input int t);
        logic [127:0] r;
        for (int i = 0; i < 4; i++)
            r[32*i +: 32] = 32'h01010101 * 32'(t * 4 + i);
        return r;
    endfunction

    task automatic run_vec(input int i);
        @(negedge clk);
        req_valid   = 1'b1;
        req_format  = vecs[i].fmt;
        req_swizzle = vecs[i].swz;
        req_premul  = vecs[i].premul;
        req_mask    = vecs[i].mask;
        req_texels  = vecs[i].tex;
        req_tag     = 8'(5 + i);
        rsp_ready   = 1'b1;
        #1 chk($sformatf("v%0d_req_ready", i), req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk($sformatf("v%0d_valid_early", i), rsp_valid, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_valid", i), rsp_valid, 1'b1);
        chk($sformatf("v%0d_texels", i), rsp_texels, vecs[i].exp);
        chk($sformatf("v%0d_mask", i), rsp_mask, vecs[i].mask);
        chk($sformatf("v%0d_tag", i), rsp_tag, 8'(5 + i));
        exp_perf = exp_perf + 32'($countones(vecs[i].mask));
        @(negedge clk);
        chk($sformatf("v%0d_valid_after", i), rsp_valid, 1'b0);
        chk($sformatf("v%0d_perf", i), perf_texels, exp_perf);
    endtask

    initial begin
        logic [5:0]   pat;
        int           sent, rcv;
        logic         prev_stall;
        logic [127:0] prev_tex;
        logic [7:0]   prev_tag;

        vecs[0]  = '{3'd0, 12'h688, 1'b0, 4'hF,
                     {32'hFFFFFFFF, 32'h00000000, 32'h80FF4000, 32'h11223344},
                     {32'hFFFFFFFF, 32'h00000000, 32'h80FF4000, 32'h11223344}};
        vecs[1]  = '{3'd1, 12'h688, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0000001F, 32'h0000F800},
                     {32'hFF000000, 32'hFF000000, 32'hFF0000FF, 32'hFFFF0000}};
        vecs[2]  = '{3'd2, 12'h688, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h00007FFF},
                     {32'h0, 32'h0, 32'h0, 32'h00FFFFFF}};
        vecs[3]  = '{3'd5, 12'h688, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h000000AB},
                     {32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFFABABAB}};
        vecs[4]  = '{3'd0, 12'h688, 1'b1, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h80FF4000},
                     {32'h0, 32'h0, 32'h0, 32'h80802000}};
        vecs[5]  = '{3'd0, 12'b101_000_001_010, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h80FF4000},
                     {32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF0040FF}};
        vecs[6]  = '{3'd4, 12'h688, 1'b0, 4'b0101,
                     {32'h00003C7E, 32'h00003C7E, 32'h00003C7E, 32'h00003C7E},
                     {32'h0, 32'h3C7E7E7E, 32'h0, 32'h3C7E7E7E}};
        vecs[7]  = '{3'd3, 12'h688, 1'b0, 4'hF,
                     {32'h0000F000, 32'h00000000, 32'h0000ABCD, 32'h00001234},
                     {32'hFF000000, 32'h00000000, 32'hAABBCCDD, 32'h11223344}};
        vecs[8]  = '{3'd6, 12'h688, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h00000000, 32'h0000005A},
                     {32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h5AFFFFFF}};
        vecs[9]  = '{3'd7, 12'h688, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h000000C3},
                     {32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'hC3FFFFFF}};
        vecs[10] = '{3'd0, 12'h688, 1'b1, 4'hF,
                     {32'h0, 32'h0, 32'h00FFFFFF, 32'hFFFFFFFF},
                     {32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF}};
        vecs[11] = '{3'd5, 12'hD63, 1'b0, 4'hF,
                     {32'h0, 32'h0, 32'h0, 32'h000000AB},
                     {32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF}};

        reset_n = 1'b0;
        req_valid = 1'b0; req_mask = '0; req_format = '0; req_swizzle = 12'h688;
        req_premul = 1'b0; req_texels = '0; req_tag = '0; rsp_ready = 1'b1;
        #3;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_texels", rsp_texels, 128'h0);
        chk("rst_tag", rsp_tag, 8'h0);
        chk("rst_mask", rsp_mask, 4'h0);
        chk("rst_perf", perf_texels, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec(i);

        // Backpressured stream of 8 requests, tags 0..7.
        pat = 6'b110100;
        sent = 0; rcv = 0; prev_stall = 1'b0; prev_tex = '0; prev_tag = '0;
        req_format = 3'd0; req_swizzle = 12'h688; req_premul = 1'b0; req_mask = 4'hF;
        for (int cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
            @(negedge clk);
            rsp_ready = pat[cyc % 6];
            if (sent < 8) begin
                req_valid  = 1'b1;
                req_tag    = 8'(sent);
                req_texels = stex(sent);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("stall_hold_texels", rsp_texels, prev_tex);
                chk("stall_hold_tag", rsp_tag, prev_tag);
                chk("stall_hold_valid", rsp_valid, 1'b1);
            end
            if (!req_ready)
                chk("ready_low_only_when_full", rsp_valid && !rsp_ready, 1'b1);
            if (rsp_valid && rsp_ready) begin
                chk("stream_tag", rsp_tag, 8'(rcv));
                chk("stream_texels", rsp_texels, stex(rcv));
                rcv++;
                exp_perf = exp_perf + 32'd4;
            end
            if (req_valid && req_ready)
                sent++;
            prev_stall = rsp_valid && !rsp_ready;
            prev_tex   = rsp_texels;
            prev_tag   = rsp_tag;
        end
        chk("stream_count", 128'(rcv), 128'd8);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stream_no_dup", rsp_valid, 1'b0);
        end
        chk("stream_perf", perf_texels, exp_perf);

        // Fill both stages under backpressure, then reset mid-cycle.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_tag = 8'hA0; req_texels = stex(1);
        #1 chk("fill_ready0", req_ready, 1'b1);
        @(negedge clk);
        req_tag = 8'hA1; req_texels = stex(2);
        #1 chk("fill_ready1", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("full_rsp_valid", rsp_valid, 1'b1);
        chk("full_req_ready", req_ready, 1'b0);
        chk("full_tag", rsp_tag, 8'hA0);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_perf", perf_texels, 32'h0);
        chk("mid_rst_ready", req_ready, 1'b1);
        chk("mid_rst_tag", rsp_tag, 8'h0);
        chk("mid_rst_texels", rsp_texels, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        exp_perf = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tex_format_pipe.md
Name: tex_format_pipe

Overview:
- Multi-lane, pipelined successor to the single-texel combinational format decoder.
- Expands NUM_LANES raw texels per request from one of seven packed formats to A8R8G8B8, with optional alpha premultiply and per-channel swizzle.
- Uses a 2-stage valid/ready pipeline with full backpressure and a tag passthrough.
- Sits between the texture memory response path and the texture sampler/filter.

Parameters:
- NUM_LANES, 4, texels per request.
- TAG_WIDTH, 8, opaque request tag width.
- PERF_CTR_BITS, 32, width of the converted-texel counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_mask  in  NUM_LANES  active-lane mask.
- req_format  in  3  texel format code.
- req_swizzle  in  12  four 3-bit output channel selects.
- req_premul  in  1  premultiply B,G,R by A.
- req_texels  in  NUM_LANES*32  raw texels; lane i is bits [32i+31:32i].
- req_tag  in  TAG_WIDTH  tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_mask  out  NUM_LANES  lane mask, passed through.
- rsp_texels  out  NUM_LANES*32  converted texels; byte0=B, byte1=G, byte2=R, byte3=A.
- rsp_tag  out  TAG_WIDTH  tag, passed through.
- perf_texels  out  PERF_CTR_BITS  count of active lanes delivered.

Behaviour:
- Reset (reset_n low, asynchronous): both stage valids 0, all data registers 0, perf_texels 0. Hence rsp_valid=0, rsp_texels/mask/tag=0, req_ready=1 after reset.
- Format codes:
  - 0 A8R8G8B8: passthrough.
  - 1 R5G6B5: 5/6-bit fields are bit-replicated to 8 bits (B={in[4:0],in[4:2]}, G={in[10:5],in[10:9]}, R={in[15:11],in[15:13]}); A=FF.
  - 2 A1R5G5B5: 5-bit fields replicated the same way; A={8{in[15]}}.
  - 3 A4R4G4B4: each nibble duplicated.
  - 4 A8L8: B=G=R=in[7:0], A=in[15:8].
  - 5 L8: B=G=R=in[7:0], A=FF.
  - 6 A8, and codes 7 (reserved): B=G=R=FF, A=in[7:0].
- Stage 1 (S1) registers the unpacked A8R8G8B8 per lane plus mask, tag, swizzle and premul.
- Stage 2 (S2) computes premultiply, then swizzle, and registers the outputs. rsp_* are driven directly from the S2 registers.
- Premultiply (req_premul=1): for c in B,G,R, t=c*A+128 (17 bits), c'=(t+(t>>8))>>8 (exact rounded c*A/255). A is unchanged. With premul=0, channels are unchanged.
- Swizzle: field k = swizzle[3k+2:3k] selects output byte k. Codes 0=B, 1=G, 2=R, 3=A (post-premul values), 4=00, 5=FF, 6-7=00. Identity is 12'h688.
- Inactive lanes (mask bit 0): output texel forced to 32'h0 at S2. The mask itself passes through unchanged.
- Handshake:
  - s2_advance = !s2_valid || rsp_ready.
  - s1_advance = !s1_valid || s2_advance.
  - req_ready = s1_advance. req_ready is combinational from rsp_ready and the valid registers, with no dependence on req_valid.
- Latency: exactly 2 cycles from the accepting edge to rsp_valid, with no stall.
- Throughput: 1 request/cycle while rsp_ready=1.
- Bubbles collapse: an empty S2 accepts from S1 even when rsp_ready=0.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable. A second request may then be held in S1. No data is lost or duplicated.
- Simultaneous accept at input and consume at output in the same cycle: both occur, and the pipeline stays full.
- perf_texels increments by popcount(rsp_mask) on each rsp fire. It wraps modulo 2^PERF_CTR_BITS and is never cleared except by reset.
- Reset asserted mid-operation: all in-flight requests are discarded and nothing is emitted after reset release until new requests arrive.

Test Plan:
- Reset, then one request: format 0, swizzle 688, premul 0, mask F, lanes 0x11223344/0x80FF4000/0/FFFFFFFF, tag 5, rsp_ready=1 → rsp_valid exactly 2 cycles later, texels identical, tag 5, perf_texels=4.
- Format 1, lane0=0x0000F800, lane1=0x0000001F; format 2, lane0=0x00007FFF; format 5, lane0=0x000000AB → 0xFFFF0000, 0xFF0000FF; 0x00FFFFFF; 0xFFABABAB.
- Format 0, lane0=0x80FF4000, premul 1 → 0x80802000. Same request with swizzle 12'b101_000_001_010 (B←R, G←G, R←B, A←FF) and premul 0 → 0xFF0040FF.
- Back-to-back stream of 8 requests, tags 0..7, rsp_ready toggled by a 0,0,1,0,1,1 pattern → all 8 delivered in order with no duplicates. Outputs are stable while stalled, and req_ready=0 only when both stages are full and rsp_ready=0.
- Mask 4'b0101 on format 4, lanes 0x00003C7E → lanes 0 and 2 = 0x3C7E7E7E, lanes 1 and 3 = 0. perf_texels increases by 2.
- Fill both stages with rsp_ready=0, then pulse reset_n low asynchronously mid-cycle → rsp_valid and perf_texels drop to 0 immediately and req_ready=1. No stale response appears after release.
